// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter that lets N_REQ byte-stream requesters share one
//   uart_tx instance. The winning requester keeps the grant for a whole
//   message, which ends on the byte flagged by i_last. Frames from
//   different sources therefore never interleave on the line. Each byte is
//   paced on the transmitter's busy flag.
//
// Ports
//   i_clk      clock, rising edge
//   i_rst_n    synchronous active-low reset
//   i_req      per-requester byte valid (level, held until acked)
//   i_data     requester k byte at [8k+7:8k]
//   i_last     requester k byte closes its message
//   o_ack      one-cycle pulse, requester k byte accepted
//   o_grant    one-hot owner of the UART, all-zero when free
//   o_tx_data  byte to uart_tx i_tx_data (held between strobes)
//   o_tx_we    one-cycle write strobe to uart_tx i_we_h
//   i_tx_busy  uart_tx o_busy_h
//   o_busy     high while a grant is held or a byte is in flight
module uart_tx_arbiter #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [N_REQ-1:0]     i_req,
    input  logic [8*N_REQ-1:0]   i_data,
    input  logic [N_REQ-1:0]     i_last,
    output logic [N_REQ-1:0]     o_ack,
    output logic [N_REQ-1:0]     o_grant,
    output logic [7:0]           o_tx_data,
    output logic                 o_tx_we,
    input  logic                 i_tx_busy,
    output logic                 o_busy
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYC);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_HOLD1,
        S_HOLD2,
        S_WAIT
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   own_q;
    logic [IDX_W-1:0]   last_owner_q;
    logic               last_flag_q;
    logic [TMO_W-1:0]   tmo_q;
    logic [N_REQ-1:0]   grant_q;
    logic [N_REQ-1:0]   ack_q;
    logic [7:0]         tx_data_q;
    logic               tx_we_q;
    logic               busy_q;

    // Round-robin search starting just after the previous owner.
    logic               rr_hit;
    logic [IDX_W-1:0]   rr_idx;
    logic [IDX_W-1:0]   cand_idx;

    always_comb begin
        rr_hit   = 1'b0;
        rr_idx   = '0;
        cand_idx = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand_idx = IDX_W'((32'(last_owner_q) + k) % N_REQ);
            if (!rr_hit && i_req[cand_idx]) begin
                rr_hit = 1'b1;
                rr_idx = cand_idx;
            end
        end
    end

    // Only the owner's request/data/last lanes are ever looked at.
    logic               own_req;
    logic               own_last;
    logic [7:0]         own_data;

    always_comb begin
        own_req  = 1'b0;
        own_last = 1'b0;
        own_data = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (own_q == IDX_W'(k)) begin
                own_req  = i_req[k];
                own_last = i_last[k];
                own_data = i_data[8*k +: 8];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            own_q        <= '0;
            last_owner_q <= IDX_W'(N_REQ - 1);
            last_flag_q  <= 1'b0;
            tmo_q        <= '0;
            grant_q      <= '0;
            ack_q        <= '0;
            tx_data_q    <= '0;
            tx_we_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            // Strobes are single-cycle; every state except an accepting
            // SEND leaves them low.
            ack_q   <= '0;
            tx_we_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // Waiting for i_tx_busy low also lets a frame left on
                    // the line by a reset finish untouched.
                    if (!i_tx_busy && rr_hit) begin
                        grant_q <= N_REQ'(1) << rr_idx;
                        own_q   <= rr_idx;
                        busy_q  <= 1'b1;
                        tmo_q   <= '0;
                        state_q <= S_SEND;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                S_SEND: begin
                    if (own_req) begin
                        tx_data_q   <= own_data;
                        tx_we_q     <= 1'b1;
                        ack_q       <= grant_q;
                        last_flag_q <= own_last;
                        tmo_q       <= '0;
                        state_q     <= S_HOLD1;
                    end else if (tmo_q >= TMO_LAST) begin
                        // Counter parks at TIMEOUT_CYC until the next grant.
                        tmo_q        <= TMO_MAX;
                        grant_q      <= '0;
                        busy_q       <= 1'b0;
                        last_owner_q <= own_q;
                        state_q      <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                S_HOLD1: state_q <= S_HOLD2;
                S_HOLD2: state_q <= S_WAIT;
                S_WAIT: begin
                    if (!i_tx_busy) begin
                        if (last_flag_q) begin
                            grant_q      <= '0;
                            busy_q       <= 1'b0;
                            last_owner_q <= own_q;
                            state_q      <= S_IDLE;
                        end else begin
                            state_q <= S_SEND;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_ack     = ack_q;
    assign o_grant   = grant_q;
    assign o_tx_data = tx_data_q;
    assign o_tx_we   = tx_we_q;
    assign o_busy    = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Directed and randomized bench for uart_tx_arbiter with four requesters
//   and a 16-cycle timeout. Requesters are byte queues; the transmitter is
//   a busy model that rises one cycle after it sees a write strobe.
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  last;
    logic        tx_busy;
    logic [3:0]  ack;
    logic [3:0]  grant;
    logic [7:0]  tx_data;
    logic        tx_we;
    logic        obusy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TMO)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_req     (req),
        .i_data    (data),
        .i_last    (last),
        .o_ack     (ack),
        .o_grant   (grant),
        .o_tx_data (tx_data),
        .o_tx_we   (tx_we),
        .i_tx_busy (tx_busy),
        .o_busy    (obusy)
    );

    int nchk = 0;
    int nerr = 0;

    // requester queues: {last, byte}
    logic [8:0] rq [4][$];

    int         cyc = 0;
    int         model_last = 3;
    logic [3:0] prev_grant = '0;
    logic       prev_we = 1'b0;
    int         busy_cnt = 0;
    int         busy_len = 10;
    logic       busy_force = 1'b0;
    logic       expect_msg_end = 1'b1;
    logic [7:0] last_tx = '0;
    int         last_we_cyc = -100;
    logic [3:0] last_sent = '0;
    int         gorder[$];
    int         we_cyc[$];
    logic [7:0] tx_log[$];
    int         rel_cyc = 0;
    int         pushed = 0;
    int         sent = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input int lo, input logic [3:0] r);
        for (int i = 1; i <= 4; i++) begin
            if (r[(lo + i) % 4]) return (lo + i) % 4;
        end
        return -1;
    endfunction

    function automatic int oh_idx(input logic [3:0] g);
        for (int k = 0; k < 4; k++) if (g[k]) return k;
        return -1;
    endfunction

    function automatic bit all_empty();
        for (int k = 0; k < 4; k++) if (rq[k].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drive();
        for (int k = 0; k < 4; k++) begin
            if (rq[k].size() > 0) begin
                req[k]         = 1'b1;
                data[8*k +: 8] = rq[k][0][7:0];
                last[k]        = rq[k][0][8];
            end else begin
                req[k]         = 1'b0;
                data[8*k +: 8] = 8'($urandom);
                last[k]        = 1'($urandom);
            end
        end
        tx_busy = busy_force || (busy_cnt != 0);
    endtask

    task automatic push_byte(input int k, input logic [7:0] b, input logic l);
        rq[k].push_back({l, b});
        pushed++;
    endtask

    task automatic push_rand_msg(input int k, input int len);
        for (int i = 0; i < len; i++) push_byte(k, 8'($urandom), (i == len - 1));
    endtask

    task automatic tick();
        logic [3:0] req_e;
        logic       busy_e;
        logic       rst_e;
        int         own;
        int         exp;
        req_e  = req;
        busy_e = tx_busy;
        rst_e  = rst_n;
        @(posedge clk);
        #1;
        cyc++;
        if (busy_cnt > 0) busy_cnt--;
        if (prev_we) busy_cnt = busy_len;
        prev_we = tx_we;
        if (!rst_e) begin
            model_last  = 3;
            last_tx     = '0;
            last_we_cyc = -100;
        end else begin
            chk("busy_vs_grant", 32'(obusy), 32'(|grant));
            chk("grant_onehot0", 32'($onehot0(grant)), 1);
            if (tx_we) begin
                own = oh_idx(grant);
                chk("ack_with_we", 32'(ack), 32'(grant));
                chk("we_has_owner", 32'(own >= 0), 1);
                if (own >= 0) begin
                    chk("owner_pending", 32'(rq[own].size() > 0), 1);
                    if (rq[own].size() > 0) chk("tx_byte", 32'(tx_data), 32'(rq[own][0][7:0]));
                end
                chk("we_spacing_min4", 32'((cyc - last_we_cyc) >= 4), 1);
                last_tx     = tx_data;
                last_we_cyc = cyc;
                we_cyc.push_back(cyc);
                tx_log.push_back(tx_data);
            end else begin
                chk("ack_idle", 32'(ack), 0);
                chk("tx_data_hold", 32'(tx_data), 32'(last_tx));
            end
            if (prev_grant == 4'b0 && grant != 4'b0) begin
                exp = rr_pick(model_last, req_e);
                chk("grant_busy_low", 32'(busy_e), 0);
                chk("grant_rr", 32'(grant), (exp >= 0) ? (32'd1 << exp) : 32'd0);
                gorder.push_back(oh_idx(grant));
            end else if (prev_grant != 4'b0 && grant == 4'b0) begin
                own        = oh_idx(prev_grant);
                model_last = own;
                rel_cyc    = cyc;
                if (expect_msg_end) chk("release_at_last", 32'(last_sent[own]), 1);
            end else if (prev_grant != 4'b0) begin
                chk("grant_stable", 32'(grant), 32'(prev_grant));
            end
        end
        prev_grant = grant;
        for (int k = 0; k < 4; k++) begin
            if (ack[k] && rq[k].size() > 0) begin
                last_sent[k] = rq[k][0][8];
                void'(rq[k].pop_front());
                sent++;
            end
        end
        drive();
    endtask

    task automatic wait_idle(input int limit);
        bit done;
        done = 1'b0;
        for (int i = 0; i < limit && !done; i++) begin
            if (all_empty() && grant == 4'b0 && !tx_busy && !prev_we && busy_cnt == 0)
                done = 1'b1;
            else
                tick();
        end
        chk("idle_reached", 32'(done), 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive();
        tick();
        rst_n = 1'b1;
        drive();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"},   32'(grant),   0);
        chk({tag, "_ack"},     32'(ack),     0);
        chk({tag, "_we"},      32'(tx_we),   0);
        chk({tag, "_txdata"},  32'(tx_data), 0);
        chk({tag, "_busy"},    32'(obusy),   0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int g0;
        int w;
        logic [7:0] hi_bytes [3];
        hi_bytes[0] = 8'h48;
        hi_bytes[1] = 8'h69;
        hi_bytes[2] = 8'h0D;

        rst_n = 1'b0;
        req = '0; data = '0; last = '0; tx_busy = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");

        // single message "Hi\r" from requester 1, 10-cycle busy
        rst_n = 1'b1;
        busy_len = 10;
        we_cyc.delete(); tx_log.delete();
        push_byte(1, 8'h48, 1'b0);
        push_byte(1, 8'h69, 1'b0);
        push_byte(1, 8'h0D, 1'b1);
        drive();
        tick();
        chk("grant_latency", 32'(grant), 32'h2);
        chk("busy_latency", 32'(obusy), 1);
        g0 = cyc;
        wait_idle(300);
        chk("hi_we_count", 32'(we_cyc.size()), 3);
        if (we_cyc.size() == 3) begin
            chk("hi_first_we", 32'(we_cyc[0]), 32'(g0 + 1));
            chk("hi_spacing1", 32'(we_cyc[1] - we_cyc[0]), 13);
            chk("hi_spacing2", 32'(we_cyc[2] - we_cyc[1]), 13);
            chk("hi_release", 32'(rel_cyc), 32'(we_cyc[2] + 12));
            for (int i = 0; i < 3; i++) chk("hi_byte", 32'(tx_log[i]), 32'(hi_bytes[i]));
        end

        // contention between requesters 0 and 2
        do_reset();
        gorder.delete();
        push_rand_msg(0, 2);
        push_rand_msg(2, 2);
        drive();
        wait_idle(300);
        push_rand_msg(0, 2);
        push_rand_msg(2, 2);
        drive();
        wait_idle(300);
        chk("cont_grants", 32'(gorder.size()), 4);
        if (gorder.size() == 4)
            for (int i = 0; i < 4; i++) chk("cont_order", 32'(gorder[i]), 32'((i % 2) * 2));

        // fairness: all four with 1-byte messages
        do_reset();
        busy_len = 3;
        gorder.delete();
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < 4; k++) push_rand_msg(k, 1);
        drive();
        wait_idle(500);
        chk("fair_grants", 32'(gorder.size()), 12);
        if (gorder.size() == 12)
            for (int i = 0; i < 12; i++) chk("fair_order", 32'(gorder[i]), 32'(i % 4));

        // timeout: requester 3 sends a non-last byte then goes quiet
        do_reset();
        busy_len = 10;
        push_byte(3, 8'($urandom), 1'b0);
        drive();
        n = 0;
        while (!ack[3] && n < 20) begin tick(); n++; end
        chk("tmo_ack_seen", 32'(ack[3]), 1);
        push_rand_msg(0, 1);
        drive();
        expect_msg_end = 1'b0;
        repeat (27) tick();
        chk("tmo_grant_held", 32'(grant), 32'h8);
        tick();
        chk("tmo_released", 32'(grant), 0);
        expect_msg_end = 1'b1;
        tick();
        chk("tmo_next_grant", 32'(grant), 32'h1);
        wait_idle(300);

        // reset while the owner waits on a busy transmitter
        do_reset();
        busy_len = 10;
        push_rand_msg(1, 3);
        drive();
        n = 0;
        while (!tx_we && n < 20) begin tick(); n++; end
        chk("rm_we_seen", 32'(tx_we), 1);
        repeat (3) tick();
        rq[1].delete();
        push_rand_msg(2, 2);
        push_rand_msg(0, 2);
        rst_n = 1'b0;
        drive();
        tick();
        chk_all_zero("rm");
        rst_n = 1'b1;
        drive();
        n = 0;
        while (tx_busy && n < 50) begin
            chk("rm_no_grant_busy", 32'(grant), 0);
            tick();
            n++;
        end
        chk("rm_busy_fell", 32'(tx_busy), 0);
        chk("rm_grant_wait", 32'(grant), 0);
        tick();
        chk("rm_grant0", 32'(grant), 32'h1);
        wait_idle(300);

        // busy gating: no transmitter busy at all -> HOLD1/HOLD2 still spaced
        do_reset();
        busy_len = 0;
        we_cyc.delete();
        push_rand_msg(2, 3);
        drive();
        wait_idle(200);
        chk("bg_we_count", 32'(we_cyc.size()), 3);
        if (we_cyc.size() == 3) begin
            chk("bg_spacing1", 32'(we_cyc[1] - we_cyc[0]), 4);
            chk("bg_spacing2", 32'(we_cyc[2] - we_cyc[1]), 4);
        end

        // busy gating: busy forced high for 50 cycles after a strobe
        push_rand_msg(1, 2);
        drive();
        n = 0;
        while (!tx_we && n < 20) begin tick(); n++; end
        chk("bg_first_we", 32'(tx_we), 1);
        w = cyc;
        busy_force = 1'b1;
        drive();
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("bg_no_we", 32'(tx_we), 0);
        end
        busy_force = 1'b0;
        drive();
        n = 0;
        while (!tx_we && n < 20) begin tick(); n++; end
        chk("bg_second_we_cycle", 32'(cyc - w), 52);
        wait_idle(200);

        // randomized traffic
        do_reset();
        pushed = 0;
        sent   = 0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                n = int'($urandom_range(0, 3));
                if (rq[n].size() < 8) push_rand_msg(n, int'($urandom_range(1, 4)));
            end
            busy_len = int'($urandom_range(0, 12));
            drive();
            tick();
        end
        wait_idle(4000);
        chk("rand_bytes", 32'(sent), 32'(pushed));

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one `uart_tx` instance between `N_REQ` byte-stream requesters, such as string senders, status reporters and debug dumpers. A requester holds the grant for a whole message, delimited by `i_last`, so frames from different sources never interleave on the line. The block drives the `uart_tx` write port (`i_tx_data`/`i_we_h`) and paces each byte on its `o_busy_h` status.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..8).
- `TIMEOUT_CYC`, 1023: idle cycles inside a message after which the grant is revoked (1..65535).

Ports:
- `i_clk`  in  1  clock, rising edge; single clock domain.
- `i_rst_n`  in  1  reset, synchronous, active-low.
- `i_req`  in  N_REQ  per-requester byte valid; level, held until acked.
- `i_data`  in  8*N_REQ  byte of requester k at `[8k+7:8k]`.
- `i_last`  in  N_REQ  byte of requester k is the last byte of its message.
- `o_ack`  out  N_REQ  one-cycle pulse: requester k's byte was accepted.
- `o_grant`  out  N_REQ  one-hot owner of the UART; all-zero when free.
- `o_tx_data`  out  8  to `uart_tx` `i_tx_data`.
- `o_tx_we`  out  1  to `uart_tx` `i_we_h`; one-cycle strobe.
- `i_tx_busy`  in  1  from `uart_tx` `o_busy_h`.
- `o_busy`  out  1  high while any grant is held or a byte is in flight.

## Operation
- Reset (`i_rst_n`=0 at an edge) produces the following values:
  - `o_grant`, `o_ack`, `o_tx_we`, `o_tx_data`, `o_busy` = 0.
  - State = IDLE.
  - Round-robin pointer `last_owner` = N_REQ-1, so requester 0 wins first.
  - Timeout counter = 0.
- FSM states:
  - **IDLE**: if `i_tx_busy`=0 and `i_req`≠0, grant the first set bit searching `last_owner+1, +2, …` modulo N_REQ. Set `o_grant`, set `o_busy`=1, go to SEND. Otherwise stay in IDLE with `o_busy`=0.
  - **SEND**: if `i_req[own]`=1, do all of the following and go to HOLD1:
    - `o_tx_data` ← `i_data[own]`, `o_tx_we` ← 1, `o_ack[own]` ← 1.
    - `last_flag` ← `i_last[own]`, timeout counter ← 0.
  - **SEND**, `i_req[own]`=0: increment the timeout counter. When it reaches `TIMEOUT_CYC`, clear `o_grant`, set `last_owner` ← own, go to IDLE.
  - **HOLD1**: `o_tx_we` ← 0, `o_ack` ← 0; go to HOLD2. This covers the `uart_tx` busy-assert latency.
  - **HOLD2**: go to WAIT.
  - **WAIT**: stay while `i_tx_busy`=1. When it is 0, then:
    - if `last_flag`=1: clear `o_grant`, set `last_owner` ← own, go to IDLE;
    - otherwise go to SEND.
- Requesters with `i_req`=1 and no grant are stalled; no ack, no side effects.
- Requester contract:
  - Present the next byte, or drop `i_req`, in the cycle after `o_ack`.
  - `i_req` changes by a non-owner, or by the owner outside SEND, are ignored.
- `o_tx_data` holds its value between strobes.
- The `i_data`/`i_last` of non-granted requesters are never sampled.

## Timing
- Grant latency: `i_req` rises in cycle 0 with the arbiter idle → `o_grant` and `o_busy` high in cycle 1 (SEND).
- Byte accept:
  - `i_req[own]` high in a SEND cycle c → `o_tx_we`, `o_ack[own]` and the new `o_tx_data` all valid in cycle c+1, exactly one cycle.
  - The earliest next SEND is cycle c+4, and then only if `i_tx_busy` is already low.
- Message end: WAIT sees `i_tx_busy`=0 with `last_flag` → `o_grant`=0 the next cycle. The earliest new grant follows one cycle after that.
- Simultaneous events:
  - Several requests in IDLE: exactly one grant, by the round-robin order.
  - The owner drops `i_req` in the same cycle the timeout would expire: the grant is released, with no ack.
- Reset mid-message:
  - All outputs clear on the next edge; a partial message is abandoned.
  - IDLE then refuses to grant until `i_tx_busy`=0, so a frame already started on the line completes undisturbed.
- Timeout counter: width = clog2(TIMEOUT_CYC+1); saturates; never wraps.

## Test plan
- **Single message:** requester 1 sends "Hi\r" (0x48, 0x69, 0x0D, last on 0x0D) with a busy model of 10 cycles per byte. Expect:
  - three `o_tx_we` pulses with those bytes, each with `o_ack[1]`;
  - `o_grant`=0b0010 throughout, then 0 after the final busy falls.
- **Contention:** requesters 0 and 2 request in the same cycle after reset, each with a 2-byte message. Expect:
  - requester 0 is served completely first, then requester 2;
  - no interleaving;
  - next, 0 and 2 requesting again → 2 is not re-granted before 0.
- **Fairness:** all 4 requesters request continuously with 1-byte messages → grant order 0,1,2,3,0,1… for 12 grants.
- **Timeout:** requester 3 sends one non-last byte, then drops `i_req` with `TIMEOUT_CYC`=16. Expect `o_grant` clear exactly 16 SEND cycles later, and requester 0, pending, granted the following cycle.
- **Reset mid-message:** `i_rst_n`=0 while in WAIT with `i_tx_busy`=1. Expect:
  - all outputs 0 next cycle;
  - a pending request is not granted until `i_tx_busy` falls;
  - after that, requester 0 has priority.
- **Busy gating:** hold `i_tx_busy`=1 for 50 cycles after a strobe. Expect no second `o_tx_we` before busy falls, and HOLD1/HOLD2 never skipped.
